dclk_period_checker: RTL and testbench
======================================

// Module: dclk_period_checker
// PURPOSE
// - Downstream monitor of the clock-divider output dclk_o; runs in the clk_i domain and treats dclk as a data signal.
// - Detects dclk rising edges and measures the period in clk_i cycles.
// - Compares the period against the expected 2^(BASE_LOG2-sel) cycles and flags match, mismatch and timeout (dclk stuck).
// - Hardware replacement for the bench-side $realtime period check; used for on-chip self-test of the divider.
// PARAMETERS
// - BASE_LOG2   7    log2 of divide ratio at sel=0; expected period = 1 << (BASE_LOG2 - sel_i)
// - CNT_W       10   period counter / period_o width; must satisfy 2^CNT_W > TIMEOUT_CYC
// - TIMEOUT_CYC 512  clk cycles without a dclk rise before timeout_o fires
// - TOL         0    allowed |measured - expected| in clk cycles for a match
// - ERR_W       8    width of the saturating error counter
// PORTS
// - clk_i       in   1      system clock, same clock as the divider
// - rstn_i      in   1      asynchronous active-low reset
// - en_i        in   1      checker enable; low = IDLE
// - sel_i       in   2      divider select, same value as fed to the divider
// - dclk_i      in   1      divided clock from the divider (register output, clk_i-synchronous)
// - clr_i       in   1      synchronous clear of err_cnt_o and err_o
// - period_o    out  CNT_W  last measured period in clk cycles (holds until next measurement)
// - valid_o     out  1      1-cycle pulse: period_o/match_o updated
// - match_o     out  1      period_o within TOL of expected; valid with valid_o, held after
// - err_o       out  1      sticky: set on any mismatch or timeout, cleared by clr_i or en_i low
// - timeout_o   out  1      1-cycle pulse when TIMEOUT_CYC elapses without a rise
// - err_cnt_o   out  ERR_W  saturating count of mismatches + timeouts
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, dclk_q=0, counter 0, sel_q=0.
// - Edge detect: dclk_q <= dclk_i each cycle; rise = dclk_i & ~dclk_q.
// - FSM IDLE -> ARM when en_i=1. ARM -> MEAS on rise; counter set to 1.
// - MEAS: counter increments by 1 per cycle. On rise: period_o <= counter; next cycle valid_o=1. Counter reloads to 1; stay in MEAS (back-to-back measurements).
// - Timing: rises at cycles t0 and t0+P give period_o=P and a valid_o pulse at t0+P+1.
// - Compare: exp = 1 << (BASE_LOG2 - sel_q). match_o = (|counter - exp| <= TOL), registered with period_o. Mismatch sets err_o and increments err_cnt_o.
// - Timeout: in ARM or MEAS, the count of cycles since entering the state or since the last rise reaches TIMEOUT_CYC -> timeout_o pulse, err_o set, err_cnt_o+1, state -> ARM, counter 0.
// - sel change: sel_q registers sel_i. If sel_i != sel_q in MEAS, discard the current measurement (no valid_o) and go to ARM. The first period after any sel change is never checked.
// - en_i low: state -> IDLE next cycle; counter 0, err_o 0, valid_o/timeout_o 0; period_o, match_o and err_cnt_o hold.
// - Simultaneous rise and timeout (counter == TIMEOUT_CYC at the rise): the rise wins; measure normally, no timeout.
// - clr_i together with a new error: the error wins; err_cnt_o <= 1, err_o <= 1.
// - err_cnt_o saturates at all-ones; no wrap.
// - Counter never wraps; TIMEOUT_CYC bounds it below 2^CNT_W.
// - Async reset mid-measurement: immediate return to reset values; the measurement is lost.
// STRUCTURE
// - Shared package dclk_pkg holds:
//   - BASE_LOG2 default
//   - state enum {IDLE, ARM, MEAS}
//   - function exp_period(sel) returning CNT_W bits
//   The divider and this checker use the same package.
// - One sub-module: dclk_edge_det (registered rising-edge detector, async active-low reset).
// - Top level contains the FSM, counter, comparator and error counter.
// TESTING
// - sel=0, en=1, divider running: valid_o every 128 cycles, period_o=128, match_o=1, err_o=0.
// - Sweep sel=1,2,3: period_o = 64, 32, 16 after the first discarded period; no errors.
// - Drive dclk_i from the bench with period 100 at sel=0, TOL=0: match_o=0, err_o=1, err_cnt_o increments per period.
// - Hold dclk_i=0: timeout_o pulse every 512 cycles, err_cnt_o counts, state returns to ARM each time.
// - Change sel mid-measurement, then pulse en_i low: no spurious valid_o; err_o cleared; period_o holds.
// - Assert rstn_i mid-MEAS, then apply clr_i coincident with a mismatch: outputs zero during reset; err_cnt_o=1 after the clr/mismatch collision.

Source files
------------

// File: rtl/dclk_pkg.sv
// Shared definitions for the clock divider and its period checker:
// default divide exponent, checker state encoding and the expected-period helper.
package dclk_pkg;

  localparam int DCLK_BASE_LOG2 = 7;
  localparam int DCLK_CNT_W     = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } state_e;

  // Expected dclk period in clk cycles for a given divider select.
  function automatic logic [DCLK_CNT_W-1:0] exp_period(input logic [1:0] sel,
                                                       input int base_log2);
    return DCLK_CNT_W'(1) << (base_log2 - int'(sel));
  endfunction

endpackage

// File: rtl/dclk_edge_det.sv
// Rising-edge detector for a clk-synchronous level: one register of history,
// rise is combinational from the current level and the registered previous one.
module dclk_edge_det (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/dclk_period_checker.sv
// On-chip monitor of the divided clock: measures the dclk period in clk cycles,
// compares it with the expected divide ratio and tracks mismatches and stuck-clock timeouts.
module dclk_period_checker
  import dclk_pkg::*;
#(
  parameter int BASE_LOG2   = DCLK_BASE_LOG2,
  parameter int CNT_W       = 10,
  parameter int TIMEOUT_CYC = 512,
  parameter int TOL         = 0,
  parameter int ERR_W       = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic [1:0]       sel_i,
  input  logic             dclk_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             match_o,
  output logic             err_o,
  output logic             timeout_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  function automatic logic [CNT_W:0] abs_diff(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
    logic signed [CNT_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q;
  logic             rise;
  logic             meas_p0, tmo_p0, err_evt_p0, match_p0;
  logic [CNT_W-1:0] exp_p0;

  logic [CNT_W-1:0] period_p1;
  logic             vld_p1, match_p1, err_p1, tmo_p1;
  logic [ERR_W-1:0] err_cnt_p1;

  dclk_edge_det u_edge (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .d_i    (dclk_i),
    .rise_o (rise)
  );

  // Stage p0: state/counter decision and period comparison
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_i;
    end
  end

  // In ARM the counter starts at 0, so TIMEOUT_CYC cycles have elapsed at TIMEOUT_CYC-1;
  // in MEAS it restarts at 1 after each rise. A rise always beats the timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    meas_p0 = 1'b0;
    tmo_p0  = 1'b0;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = MEAS;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            tmo_p0 = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        MEAS: begin
          if (sel_i != sel_q) begin
            state_d = ARM;
            cnt_d   = '0;
          end else if (rise) begin
            meas_p0 = 1'b1;
            cnt_d   = CNT_W'(1);
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC)) begin
            tmo_p0  = 1'b1;
            state_d = ARM;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign exp_p0     = CNT_W'(exp_period(sel_q, BASE_LOG2));
  assign match_p0   = abs_diff(cnt_q, exp_p0) <= (CNT_W + 1)'(TOL);
  assign err_evt_p0 = tmo_p0 | (meas_p0 & ~match_p0);

  // Stage p1: registered results and error bookkeeping
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      period_p1  <= '0;
      vld_p1     <= 1'b0;
      match_p1   <= 1'b0;
      err_p1     <= 1'b0;
      tmo_p1     <= 1'b0;
      err_cnt_p1 <= '0;
    end else begin
      vld_p1 <= meas_p0;
      tmo_p1 <= tmo_p0;
      if (meas_p0) begin
        period_p1 <= cnt_q;
        match_p1  <= match_p0;
      end
      // A new error outranks a coincident clear.
      if (err_evt_p0) begin
        err_cnt_p1 <= clr_i ? ERR_W'(1) : sat_inc(err_cnt_p1);
      end else if (clr_i) begin
        err_cnt_p1 <= '0;
      end
      if (!en_i) begin
        err_p1 <= 1'b0;
      end else if (err_evt_p0) begin
        err_p1 <= 1'b1;
      end else if (clr_i) begin
        err_p1 <= 1'b0;
      end
    end
  end

  assign period_o  = period_p1;
  assign valid_o   = vld_p1;
  assign match_o   = match_p1;
  assign err_o     = err_p1;
  assign timeout_o = tmo_p1;
  assign err_cnt_o = err_cnt_p1;

endmodule

// File: tb/tb_dclk_period_checker.sv
// Randomized scoreboard bench for dclk_period_checker: an event-level reference model
// predicts every valid/timeout event, a monitor pops and compares whenever the DUT reports one.
module tb_dclk_period_checker;

  localparam int BASE_LOG2   = 7;
  localparam int CNT_W       = 10;
  localparam int TIMEOUT_CYC = 512;
  localparam int TOL         = 0;
  localparam int ERR_W       = 4;
  localparam int ERR_MAX     = (1 << ERR_W) - 1;

  logic             clk_i  = 1'b0;
  logic             rstn_i = 1'b1;
  logic             en_i   = 1'b0;
  logic [1:0]       sel_i  = 2'd0;
  logic             dclk_i = 1'b0;
  logic             clr_i  = 1'b0;
  logic [CNT_W-1:0] period_o;
  logic             valid_o;
  logic             match_o;
  logic             err_o;
  logic             timeout_o;
  logic [ERR_W-1:0] err_cnt_o;

  always #5 clk_i = ~clk_i;

  dclk_period_checker #(
    .BASE_LOG2   (BASE_LOG2),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TOL         (TOL),
    .ERR_W       (ERR_W)
  ) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .en_i      (en_i),
    .sel_i     (sel_i),
    .dclk_i    (dclk_i),
    .clr_i     (clr_i),
    .period_o  (period_o),
    .valid_o   (valid_o),
    .match_o   (match_o),
    .err_o     (err_o),
    .timeout_o (timeout_o),
    .err_cnt_o (err_cnt_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit tmo;
    int period;
    bit match;
    bit err;
    int errcnt;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  // Reference model: mode 0 idle, 1 armed, 2 measuring; m_start is the cycle the
  // current wait began (arm entry or last rise), so elapsed = m_cyc - m_start.
  int       m_mode, m_start, m_cyc, m_period, m_errcnt;
  bit       m_match, m_err, m_dq;
  bit [1:0] m_selq;

  int gen_per = 0;
  int gen_ph  = 0;
  bit clr_on_rise = 0;
  bit clr_hit     = 0;

  task automatic chk(string nm, int act, int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_start = 0; m_cyc = 0; m_period = 0; m_errcnt = 0;
    m_match = 0; m_err = 0; m_dq = 0; m_selq = 2'd0;
    sbq.delete();
  endfunction

  function automatic void model_step(bit en, bit [1:0] sel, bit d, bit clr);
    bit   rise, tmo, meas, bad;
    int   expv, diff;
    exp_t e;
    rise = d && !m_dq;
    tmo  = 0;
    meas = 0;
    if (!en) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode  = 1;
      m_start = m_cyc;
    end else if (m_mode == 1) begin
      if (rise) begin
        m_mode  = 2;
        m_start = m_cyc;
      end else if (m_cyc - m_start == TIMEOUT_CYC) begin
        tmo     = 1;
        m_start = m_cyc;
      end
    end else begin
      if (sel != m_selq) begin
        m_mode  = 1;
        m_start = m_cyc;
      end else if (rise) begin
        meas     = 1;
        m_period = m_cyc - m_start;
        expv     = 2 ** (BASE_LOG2 - int'(sel));
        diff     = m_period - expv;
        if (diff < 0) diff = -diff;
        m_match  = (diff <= TOL);
        m_start  = m_cyc;
      end else if (m_cyc - m_start == TIMEOUT_CYC) begin
        tmo     = 1;
        m_mode  = 1;
        m_start = m_cyc;
      end
    end
    bad = tmo || (meas && !m_match);
    if (bad) m_errcnt = clr ? 1 : ((m_errcnt < ERR_MAX) ? m_errcnt + 1 : ERR_MAX);
    else if (clr) m_errcnt = 0;
    if (!en) m_err = 0;
    else if (bad) m_err = 1;
    else if (clr) m_err = 0;
    if (tmo || meas) begin
      e.tmo = tmo; e.period = m_period; e.match = m_match;
      e.err = m_err; e.errcnt = m_errcnt;
      sbq.push_back(e);
    end
    m_selq = sel;
    m_dq   = d;
    m_cyc++;
  endfunction

  task automatic step(bit en, bit [1:0] sel, bit clr_v);
    bit d;
    @(negedge clk_i);
    d = (gen_per != 0) && (gen_ph < gen_per / 2);
    if (gen_per != 0) gen_ph = (gen_ph + 1) % gen_per;
    if (clr_on_rise && en && d && !m_dq && m_mode == 2 && sel == m_selq) begin
      clr_v       = 1;
      clr_hit     = 1;
      clr_on_rise = 0;
    end
    rstn_i = 1'b1;
    en_i   = en;
    sel_i  = sel;
    dclk_i = d;
    clr_i  = clr_v;
    model_step(en, sel, d, clr_v);
  endtask

  task automatic run(int n, bit en, bit [1:0] sel);
    repeat (n) step(en, sel, 1'b0);
  endtask

  task automatic set_per(int p);
    gen_per = p;
    gen_ph  = (p != 0) ? gen_ph % p : 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_period"},  int'(period_o),  0);
    chk({tag, "_valid"},   int'(valid_o),   0);
    chk({tag, "_match"},   int'(match_o),   0);
    chk({tag, "_err"},     int'(err_o),     0);
    chk({tag, "_timeout"}, int'(timeout_o), 0);
    chk({tag, "_errcnt"},  int'(err_cnt_o), 0);
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rstn_i = 1'b0;
    en_i   = 1'b0;
    clr_i  = 1'b0;
    dclk_i = 1'b0;
    #1;
    chk_zero("midreset");
    model_reset();
  endtask

  always @(posedge clk_i) begin
    #1;
    if (rstn_i) begin
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("evt_valid",   int'(valid_o),   mon_e.tmo ? 0 : 1);
        chk("evt_timeout", int'(timeout_o), mon_e.tmo ? 1 : 0);
        if (!mon_e.tmo) begin
          chk("evt_period", int'(period_o), mon_e.period);
          chk("evt_match",  int'(match_o),  int'(mon_e.match));
        end
        chk("evt_err",    int'(err_o),     int'(mon_e.err));
        chk("evt_errcnt", int'(err_cnt_o), mon_e.errcnt);
      end else if (valid_o || timeout_o) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_event: valid_o=%0d timeout_o=%0d, expected no event (t=%0t)",
                 valid_o, timeout_o, $time);
      end
    end
  end

  initial begin
    bit [1:0] s;
    int       p, n, r;
    model_reset();
    #2 rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk_zero("reset");

    // Nominal divide-by-128
    set_per(128);
    run(700, 1'b1, 2'd0);
    chk("nominal_err", int'(err_o), int'(m_err));

    // Select sweep with the matching divider period
    for (int k = 1; k <= 3; k++) begin
      set_per(128 >> k);
      run(8 * (128 >> k) + int'($urandom_range(0, 40)), 1'b1, 2'(k));
      chk("sweep_err", int'(err_o), int'(m_err));
      chk("sweep_period", int'(period_o), m_period);
    end

    // Wrong period: mismatches accumulate and saturate
    set_per(100);
    run(2000, 1'b1, 2'd0);
    chk("mismatch_err", int'(err_o), int'(m_err));
    chk("mismatch_satcnt", int'(err_cnt_o), m_errcnt);
    step(1'b1, 2'd0, 1'b1);
    run(3, 1'b1, 2'd0);

    // Timeout boundary: 512 is measured, 513 times out first
    set_per(512);
    run(1600, 1'b1, 2'd0);
    set_per(513);
    run(1600, 1'b1, 2'd0);

    // Stuck dclk
    step(1'b1, 2'd0, 1'b1);
    set_per(0);
    run(1600, 1'b1, 2'd0);
    chk("stuck_errcnt", int'(err_cnt_o), m_errcnt);

    // Select change mid-measurement, then disable
    set_per(128);
    run(300, 1'b1, 2'd0);
    run(20, 1'b1, 2'd2);
    run(3, 1'b0, 2'd2);
    chk("disable_err", int'(err_o), int'(m_err));
    chk("disable_period_hold", int'(period_o), m_period);

    // Randomized segments
    repeat (30) begin
      s = 2'($urandom_range(0, 3));
      r = int'($urandom_range(0, 9));
      if (r <= 5)      p = 128 >> s;
      else if (r <= 7) p = int'($urandom_range(10, 300));
      else if (r == 8) p = int'($urandom_range(480, 560));
      else             p = 0;
      set_per(p);
      if (p != 0) gen_ph = int'($urandom_range(0, p - 1));
      if ($urandom_range(0, 7) == 0) run(int'($urandom_range(1, 4)), 1'b0, s);
      n = int'($urandom_range(100, 700));
      for (int i = 0; i < n; i++) step(1'b1, s, ($urandom_range(0, 59) == 0));
    end

    // Async reset while measuring, then clear colliding with a mismatch
    set_per(128);
    run(300, 1'b1, 2'd0);
    do_reset();
    set_per(100);
    gen_ph      = 0;
    clr_on_rise = 1;
    clr_hit     = 0;
    for (int i = 0; i < 1000 && !clr_hit; i++) step(1'b1, 2'd0, 1'b0);
    @(posedge clk_i);
    #2;
    if (!clr_hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL clr_collision_timeout: no measured rise within 1000 cycles");
    end else begin
      chk("clr_collision_errcnt", int'(err_cnt_o), 1);
      chk("clr_collision_err", int'(err_o), 1);
    end
    run(50, 1'b1, 2'd0);
    @(posedge clk_i);
    #2;
    chk("queue_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
